// File: rtl/spi_sram_23lc512.sv
// Behavioural model of a 64 KiB SPI SRAM (mode 0) with READ/WRITE, mode register access,
// byte/page/sequential addressing and HOLD support.
module spi_sram_23lc512 #(
  parameter int unsigned MEM_BYTES  = 65536,
  parameter int unsigned PAGE_BYTES = 32
) (
  input  logic SCK,
  input  logic RESET,
  input  logic CS_N,
  input  logic SI_SIO0,
  output logic SO_SIO1,
  input  logic HOLD_N_SIO3
);

  typedef enum logic [2:0] {
    StCmd,
    StAddr,
    StRdata,
    StWdata,
    StRdmr,
    StWrmr,
    StIgnore
  } state_e;

  localparam logic [15:0] PageMask = 16'(PAGE_BYTES - 1);

  logic [7:0]  mem [MEM_BYTES];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d, addr_inc;
  logic [6:0]  sr_q, sr_d;
  logic [1:0]  mode_q, mode_d;
  logic        rd_q, rd_d;
  logic        mem_we;
  logic [7:0]  rx_byte;
  logic [7:0]  mode_byte;
  logic        byte_done;
  logic        reading;
  logic        so_q, so_vld_q;

  assign rx_byte   = {sr_q, SI_SIO0};
  assign byte_done = (cnt_q[2:0] == 3'd7);
  assign mode_byte = {mode_q, 6'b0};
  assign reading   = (state_q == StRdata) || (state_q == StRdmr);

  // Mode bits [7:6]: 00 byte, 10 page, 01/11 sequential.
  always_comb begin
    case (mode_q)
      2'b00:   addr_inc = addr_q;
      2'b10:   addr_inc = (addr_q & ~PageMask) | ((addr_q + 16'd1) & PageMask);
      default: addr_inc = addr_q + 16'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    mem_we  = 1'b0;
    if (RESET) begin
      state_d = StCmd;
      cnt_d   = '0;
      addr_d  = '0;
      mode_d  = 2'b01;
    end else if (HOLD_N_SIO3) begin
      cnt_d = cnt_q + 4'd1;
      sr_d  = rx_byte[6:0];
      case (state_q)
        StCmd: begin
          if (byte_done) begin
            cnt_d = '0;
            case (rx_byte)
              8'h03: begin
                state_d = StAddr;
                rd_d    = 1'b1;
              end
              8'h02: begin
                state_d = StAddr;
                rd_d    = 1'b0;
              end
              8'h05:   state_d = StRdmr;
              8'h01:   state_d = StWrmr;
              default: state_d = StIgnore;
            endcase
          end
        end
        StAddr: begin
          addr_d = {addr_q[14:0], SI_SIO0};
          if (cnt_q == 4'd15) begin
            cnt_d   = '0;
            state_d = rd_q ? StRdata : StWdata;
          end
        end
        StRdata: begin
          if (byte_done) begin
            cnt_d  = '0;
            addr_d = addr_inc;
          end
        end
        StWdata: begin
          if (byte_done) begin
            cnt_d  = '0;
            addr_d = addr_inc;
            mem_we = 1'b1;
          end
        end
        StRdmr: begin
          if (byte_done) cnt_d = '0;
        end
        StWrmr: begin
          if (byte_done) begin
            cnt_d   = '0;
            mode_d  = rx_byte[7:6];
            state_d = StIgnore;
          end
        end
        StIgnore: cnt_d = cnt_q;
        default:  state_d = StIgnore;
      endcase
    end
  end

  // Deselect aborts the transfer immediately, independent of SCK.
  always_ff @(posedge SCK or posedge CS_N) begin
    if (CS_N) begin
      state_q <= StCmd;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge SCK) begin
    addr_q <= addr_d;
    sr_q   <= sr_d;
    mode_q <= mode_d;
    rd_q   <= rd_d;
    if (mem_we) mem[addr_q] <= rx_byte;
  end

  // Output bit launched on the falling edge; so_vld_q keeps SO off for the half cycle
  // between entering a read state and the first launch.
  always_ff @(negedge SCK or posedge CS_N) begin
    if (CS_N) begin
      so_q     <= 1'b0;
      so_vld_q <= 1'b0;
    end else if (HOLD_N_SIO3) begin
      so_vld_q <= reading;
      so_q     <= (state_q == StRdmr) ? mode_byte[~cnt_q[2:0]] : mem[addr_q][~cnt_q[2:0]];
    end
  end

  assign SO_SIO1 = (so_vld_q && reading && !CS_N && HOLD_N_SIO3) ? so_q : 1'bz;

endmodule

// File: tb/tb_spi_sram_23lc512.sv
// Directed bench for spi_sram_23lc512: vector table of SPI transactions plus hand-written
// hold, abort and reset sequences. SO is pulled up so high-Z reads back as 1.
module tb_spi_sram_23lc512;

  logic sck    = 1'b0;
  logic reset  = 1'b1;
  logic cs_n   = 1'b1;
  logic si     = 1'b0;
  logic hold_n = 1'b1;
  wire  so_w;

  pullup pu_so (so_w);

  int n_cmp = 0;
  int n_err = 0;

  spi_sram_23lc512 #(
    .MEM_BYTES (65536),
    .PAGE_BYTES(32)
  ) dut (
    .SCK        (sck),
    .RESET      (reset),
    .CS_N       (cs_n),
    .SI_SIO0    (si),
    .SO_SIO1    (so_w),
    .HOLD_N_SIO3(hold_n)
  );

  always #5 sck = ~sck;

  typedef enum {VWrmr, VWrite, VRead, VRdmr} kind_e;

  typedef struct {
    kind_e       kind;
    logic [15:0] addr;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  e0;
    logic [7:0]  e1;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input kind_e k, input logic [15:0] a, input int n,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] e0, input logic [7:0] e1, input string nm);
    vec_t v;
    v.kind = k;
    v.addr = a;
    v.n    = n;
    v.d0   = d0;
    v.d1   = d1;
    v.e0   = e0;
    v.e1   = e1;
    v.name = nm;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // One bit per SCK: sample SO and drive SI just after each falling edge.
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge sck);
      #1;
      rx[7-i] = so_w;
      cs_n    = 1'b0;
      si      = tx[7-i];
    end
  endtask

  task automatic end_txn();
    @(negedge sck);
    #1;
    cs_n = 1'b1;
    si   = 1'b0;
    @(negedge sck);
  endtask

  task automatic cmd_addr(input logic [7:0] op, input logic [15:0] a);
    logic [7:0] dummy;
    xfer(op, 8, dummy);
    xfer(a[15:8], 8, dummy);
    xfer(a[7:0], 8, dummy);
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input logic [7:0] d0,
                          input logic [7:0] d1);
    logic [7:0] dummy;
    cmd_addr(8'h02, a);
    xfer(d0, 8, dummy);
    if (n > 1) xfer(d1, 8, dummy);
    end_txn();
  endtask

  task automatic do_read(input logic [15:0] a, input int n, output logic [7:0] r0,
                         output logic [7:0] r1);
    r1 = '0;
    cmd_addr(8'h03, a);
    xfer(8'h00, 8, r0);
    if (n > 1) xfer(8'h00, 8, r1);
    end_txn();
  endtask

  task automatic do_wrmr(input logic [7:0] d);
    logic [7:0] dummy;
    xfer(8'h01, 8, dummy);
    xfer(d, 8, dummy);
    end_txn();
  endtask

  task automatic do_rdmr(output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0] dummy;
    xfer(8'h05, 8, dummy);
    xfer(8'h00, 8, r0);
    xfer(8'h00, 8, r1);
    end_txn();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r0, r1, rx, dummy;

    vecs.push_back(mk(VRdmr,  16'h0000, 2, 8'h00, 8'h00, 8'h40, 8'h40, "rdmr_reset"));
    vecs.push_back(mk(VWrite, 16'h0100, 2, 8'hA5, 8'h5A, 8'h00, 8'h00, "wr_0100"));
    vecs.push_back(mk(VRead,  16'h0100, 2, 8'h00, 8'h00, 8'hA5, 8'h5A, "rd_0100"));
    vecs.push_back(mk(VWrmr,  16'h0000, 1, 8'h00, 8'h00, 8'h00, 8'h00, "wrmr_byte"));
    vecs.push_back(mk(VRdmr,  16'h0000, 2, 8'h00, 8'h00, 8'h00, 8'h00, "rdmr_byte"));
    vecs.push_back(mk(VWrite, 16'h0200, 2, 8'h11, 8'h22, 8'h00, 8'h00, "wr_0200"));
    vecs.push_back(mk(VRead,  16'h0200, 2, 8'h00, 8'h00, 8'h22, 8'h22, "rd_byte_mode"));
    vecs.push_back(mk(VRead,  16'h0100, 2, 8'h00, 8'h00, 8'hA5, 8'hA5, "rd_byte_repeat"));
    vecs.push_back(mk(VWrmr,  16'h0000, 1, 8'h80, 8'h00, 8'h00, 8'h00, "wrmr_page"));
    vecs.push_back(mk(VRdmr,  16'h0000, 2, 8'h00, 8'h00, 8'h80, 8'h80, "rdmr_page"));
    vecs.push_back(mk(VWrite, 16'h003F, 2, 8'h77, 8'h88, 8'h00, 8'h00, "wr_003f"));
    vecs.push_back(mk(VRead,  16'h003F, 1, 8'h00, 8'h00, 8'h77, 8'h00, "rd_003f"));
    vecs.push_back(mk(VRead,  16'h0020, 1, 8'h00, 8'h00, 8'h88, 8'h00, "rd_page_wrap"));
    vecs.push_back(mk(VRead,  16'h003F, 2, 8'h00, 8'h00, 8'h77, 8'h88, "rd_page_burst"));
    vecs.push_back(mk(VWrmr,  16'h0000, 1, 8'hFF, 8'h00, 8'h00, 8'h00, "wrmr_11"));
    vecs.push_back(mk(VRdmr,  16'h0000, 2, 8'h00, 8'h00, 8'hC0, 8'hC0, "rdmr_11"));
    vecs.push_back(mk(VRead,  16'h0100, 2, 8'h00, 8'h00, 8'hA5, 8'h5A, "rd_mode11_seq"));
    vecs.push_back(mk(VWrmr,  16'h0000, 1, 8'h40, 8'h00, 8'h00, 8'h00, "wrmr_seq"));
    vecs.push_back(mk(VWrite, 16'hFFFF, 2, 8'h01, 8'h02, 8'h00, 8'h00, "wr_ffff"));
    vecs.push_back(mk(VRead,  16'h0000, 1, 8'h00, 8'h00, 8'h02, 8'h00, "rd_seq_wrap"));
    vecs.push_back(mk(VRead,  16'hFFFF, 2, 8'h00, 8'h00, 8'h01, 8'h02, "rd_ffff_burst"));
    vecs.push_back(mk(VWrite, 16'h0300, 2, 8'h81, 8'h3C, 8'h00, 8'h00, "wr_0300"));

    repeat (3) @(negedge sck);
    #1;
    check("reset_so_z", {7'd0, so_w}, 8'h01);
    reset = 1'b0;
    @(negedge sck);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        VWrmr:  do_wrmr(vecs[i].d0);
        VWrite: do_write(vecs[i].addr, vecs[i].n, vecs[i].d0, vecs[i].d1);
        VRead: begin
          do_read(vecs[i].addr, vecs[i].n, r0, r1);
          check({vecs[i].name, "_b0"}, r0, vecs[i].e0);
          if (vecs[i].n > 1) check({vecs[i].name, "_b1"}, r1, vecs[i].e1);
        end
        default: begin
          do_rdmr(r0, r1);
          check({vecs[i].name, "_b0"}, r0, vecs[i].e0);
          check({vecs[i].name, "_b1"}, r1, vecs[i].e1);
        end
      endcase
    end

    // Hold for 4 SCK cycles after 4 data bits of a read of 0x81 (bit 3 is 0, so Z shows as 1).
    cmd_addr(8'h03, 16'h0300);
    xfer(8'h00, 4, rx);
    @(negedge sck);
    #1;
    rx[3]  = so_w;
    hold_n = 1'b0;
    #1;
    check("hold_z_enter", {7'd0, so_w}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      @(negedge sck);
      #1;
      check("hold_z", {7'd0, so_w}, 8'h01);
    end
    hold_n = 1'b1;
    #1;
    check("hold_resume_bit", {7'd0, so_w}, 8'h00);
    for (int i = 2; i >= 0; i--) begin
      @(negedge sck);
      #1;
      rx[i] = so_w;
    end
    check("hold_byte", rx, 8'h81);
    xfer(8'h00, 8, rx);
    check("hold_next_byte", rx, 8'h3C);
    end_txn();

    // Deselect after 4 data bits of a write: target byte untouched.
    cmd_addr(8'h02, 16'h0100);
    xfer(8'hFF, 4, dummy);
    end_txn();
    do_read(16'h0100, 1, r0, r1);
    check("cs_abort_no_write", r0, 8'hA5);

    // Bytes after an unknown opcode must not act as a command.
    xfer(8'hFF, 8, dummy);
    xfer(8'h02, 8, dummy);
    xfer(8'h01, 8, dummy);
    xfer(8'h00, 8, dummy);
    xfer(8'h33, 8, dummy);
    end_txn();
    do_read(16'h0100, 1, r0, r1);
    check("ignore_no_write", r0, 8'hA5);

    // Reset in the middle of read data forces SO off.
    cmd_addr(8'h03, 16'h0300);
    xfer(8'h00, 3, rx);
    @(negedge sck);
    #1;
    check("pre_reset_drive", {7'd0, so_w}, 8'h00);
    reset = 1'b1;
    @(posedge sck);
    #1;
    check("reset_mid_read_z", {7'd0, so_w}, 8'h01);
    @(negedge sck);
    #1;
    reset = 1'b0;
    cs_n  = 1'b1;
    @(negedge sck);

    // Reset in the middle of a write in page mode: no write, mode back to sequential.
    do_wrmr(8'h80);
    cmd_addr(8'h02, 16'h0100);
    xfer(8'h00, 5, dummy);
    @(negedge sck);
    #1;
    reset = 1'b1;
    si    = 1'b0;
    @(negedge sck);
    #1;
    reset = 1'b0;
    cs_n  = 1'b1;
    @(negedge sck);
    do_rdmr(r0, r1);
    check("mode_after_reset", r0, 8'h40);
    do_read(16'h0100, 1, r0, r1);
    check("reset_no_write", r0, 8'hA5);
    do_write(16'h0101, 2, 8'hC3, 8'h96);
    do_read(16'h0101, 2, r0, r1);
    check("post_reset_rw_b0", r0, 8'hC3);
    check("post_reset_rw_b1", r1, 8'h96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
